hangman_checker: RTL and testbench

Game-side consumer of the keypad letter interface. Holds the secret word and detects each letter submission on the rising edge of `ready`. Checks the submitted ASCII letter against the word one character per cycle. Maintains the revealed-letter mask, guessed-letter set and mistake count, and declares win or lose. It sits between the keypad FSM (`ready`, `data`, `game_end`) and the display/UART layers.

---
 rtl/hangman_checker_if.sv | 35 +++
 rtl/hangman_checker.sv | 184 ++++++++++++++++++
 tb/tb_hangman_checker.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/hangman_checker_if.sv
// Letter-submission and game-status bundle between the keypad side (master)
// and the hangman checker (slave).
interface hangman_checker_if #(
  parameter int WORD_LEN = 5
);
  // Handshake: the master raises ready with data stable; only the rising edge
  // of ready counts as a submission, so ready must drop for a cycle between
  // letters. result_valid is a one-cycle pulse; hit/dup/bad are 0 outside it.
  logic                    word_load;
  logic [8*WORD_LEN-1:0]   word_in;
  logic                    ready;
  logic [7:0]              data;
  logic                    game_end;

  logic [2:0]              state;
  logic [WORD_LEN-1:0]     found_mask;
  logic [25:0]             guessed;
  logic [3:0]              mistakes;
  logic                    result_valid;
  logic                    hit;
  logic                    dup;
  logic                    bad;
  logic                    win;
  logic                    lose;

  modport master (
    output word_load, word_in, ready, data, game_end,
    input  state, found_mask, guessed, mistakes, result_valid, hit, dup, bad, win, lose
  );

  modport slave (
    input  word_load, word_in, ready, data, game_end,
    output state, found_mask, guessed, mistakes, result_valid, hit, dup, bad, win, lose
  );
endinterface

// File: rtl/hangman_checker.sv
// Hangman game core: takes letter submissions, scans the secret word one
// character per cycle, and tracks revealed letters, guesses, misses and outcome.
module hangman_checker #(
  parameter int WORD_LEN     = 5,
  parameter int MAX_MISTAKES = 6
) (
  input  logic               clk,
  input  logic               nRst,
  hangman_checker_if.slave   bus
);
  localparam int IDX_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_LEN - 1);
  localparam logic [3:0]       MAX_MISS = 4'(MAX_MISTAKES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_CHECK = 3'd2,
    S_WIN   = 3'd3,
    S_LOSE  = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic                  ready_q, ready_d;
  logic [8*WORD_LEN-1:0] word_q, word_d;
  logic [7:0]            guess_q, guess_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [WORD_LEN-1:0]   pend_q, pend_d;
  logic [WORD_LEN-1:0]   found_q, found_d;
  logic [25:0]           guessed_q, guessed_d;
  logic [3:0]            mistakes_q, mistakes_d;
  logic                  rv_q, rv_d;
  logic                  hit_q, hit_d;
  logic                  dup_q, dup_d;
  logic                  bad_q, bad_d;

  logic                  sub;
  logic                  data_is_letter;
  logic [4:0]            data_lidx;
  logic [4:0]            guess_lidx;
  logic [7:0]            cur_char;
  logic [WORD_LEN-1:0]   pre_mask;
  logic [WORD_LEN-1:0]   new_pend;
  logic                  any_hit;

  assign sub            = bus.ready & ~ready_q;
  assign data_is_letter = (bus.data >= 8'h41) && (bus.data <= 8'h5A);
  // 'A'..'Z' are 0x41..0x5A, so the low five bits minus one give the 0..25 index.
  assign data_lidx      = bus.data[4:0] - 5'd1;
  assign guess_lidx     = guess_q[4:0] - 5'd1;
  assign cur_char       = word_q[{idx_q, 3'b000} +: 8];
  assign new_pend       = pend_q | (WORD_LEN'(cur_char == guess_q) << idx_q);
  assign any_hit        = |new_pend;

  // Non-letter characters (spaces, digits) are revealed from the start.
  always_comb begin
    pre_mask = '0;
    for (int i = 0; i < WORD_LEN; i++) begin
      pre_mask[i] = !((bus.word_in[8*i +: 8] >= 8'h41) && (bus.word_in[8*i +: 8] <= 8'h5A));
    end
  end

  always_comb begin
    state_d    = state_q;
    ready_d    = bus.ready;
    word_d     = word_q;
    guess_d    = guess_q;
    idx_d      = idx_q;
    pend_d     = pend_q;
    found_d    = found_q;
    guessed_d  = guessed_q;
    mistakes_d = mistakes_q;
    rv_d       = 1'b0;
    hit_d      = 1'b0;
    dup_d      = 1'b0;
    bad_d      = 1'b0;

    if (bus.word_load) begin
      word_d     = bus.word_in;
      guess_d    = '0;
      idx_d      = '0;
      pend_d     = '0;
      found_d    = pre_mask;
      guessed_d  = '0;
      mistakes_d = '0;
      state_d    = (&pre_mask) ? S_WIN : S_PLAY;
    end else if (bus.game_end && (state_q == S_PLAY || state_q == S_CHECK)) begin
      word_d     = '0;
      guess_d    = '0;
      idx_d      = '0;
      pend_d     = '0;
      found_d    = '0;
      guessed_d  = '0;
      mistakes_d = '0;
      state_d    = S_IDLE;
    end else begin
      case (state_q)
        S_PLAY: begin
          if (sub) begin
            guess_d = bus.data;
            if (!data_is_letter) begin
              rv_d  = 1'b1;
              bad_d = 1'b1;
            end else if (guessed_q[data_lidx]) begin
              rv_d  = 1'b1;
              dup_d = 1'b1;
            end else begin
              idx_d   = '0;
              pend_d  = '0;
              state_d = S_CHECK;
            end
          end
        end
        S_CHECK: begin
          pend_d = new_pend;
          if (idx_q == LAST_IDX) begin
            // Commit: everything the display sees changes on this one edge.
            idx_d                 = '0;
            guessed_d[guess_lidx] = 1'b1;
            found_d               = found_q | new_pend;
            rv_d                  = 1'b1;
            hit_d                 = any_hit;
            if (!any_hit && mistakes_q != MAX_MISS) begin
              mistakes_d = mistakes_q + 4'd1;
            end
            if (&found_d) begin
              state_d = S_WIN;
            end else if (mistakes_d == MAX_MISS) begin
              state_d = S_LOSE;
            end else begin
              state_d = S_PLAY;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b0;
      word_q     <= '0;
      guess_q    <= '0;
      idx_q      <= '0;
      pend_q     <= '0;
      found_q    <= '0;
      guessed_q  <= '0;
      mistakes_q <= '0;
      rv_q       <= 1'b0;
      hit_q      <= 1'b0;
      dup_q      <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      word_q     <= word_d;
      guess_q    <= guess_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      found_q    <= found_d;
      guessed_q  <= guessed_d;
      mistakes_q <= mistakes_d;
      rv_q       <= rv_d;
      hit_q      <= hit_d;
      dup_q      <= dup_d;
      bad_q      <= bad_d;
    end
  end

  assign bus.state        = state_q;
  assign bus.found_mask   = found_q;
  assign bus.guessed      = guessed_q;
  assign bus.mistakes     = mistakes_q;
  assign bus.result_valid = rv_q;
  assign bus.hit          = hit_q;
  assign bus.dup          = dup_q;
  assign bus.bad          = bad_q;
  assign bus.win          = (state_q == S_WIN);
  assign bus.lose         = (state_q == S_LOSE);
endmodule

// File: tb/tb_hangman_checker.sv
// Directed bench for hangman_checker: hand-computed expectations checked with
// immediate assertions; inputs driven on the falling edge, outputs sampled there.
module tb_hangman_checker;
  logic clk;
  logic nRst;
  int   n_vec;
  int   n_err;

  int   r_lat;
  int   r_cnt;
  logic r_hit, r_dup, r_bad;

  hangman_checker_if #(.WORD_LEN(5)) bus ();

  hangman_checker #(.WORD_LEN(5), .MAX_MISTAKES(6)) dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_word(input logic [39:0] w);
    @(negedge clk);
    bus.word_in   = w;
    bus.word_load = 1'b1;
    @(negedge clk);
    bus.word_load = 1'b0;
  endtask

  // Pulse ready with one letter and watch 12 cycles for result_valid.
  // r_lat counts falling edges after the sampling edge (0 = never seen).
  task automatic submit(input logic [7:0] ch);
    @(negedge clk);
    bus.data  = ch;
    bus.ready = 1'b1;
    @(posedge clk);
    r_lat = 0; r_cnt = 0;
    r_hit = 1'b0; r_dup = 1'b0; r_bad = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) bus.ready = 1'b0;
      if (bus.result_valid) begin
        r_cnt++;
        if (r_lat == 0) begin
          r_lat = k;
          r_hit = bus.hit; r_dup = bus.dup; r_bad = bus.bad;
        end
      end
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    nRst = 1'b0;
    bus.word_load = 1'b0;
    bus.word_in   = '0;
    bus.ready     = 1'b0;
    bus.data      = '0;
    bus.game_end  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state",    bus.state, 0);
    chk("reset_found",    bus.found_mask, 0);
    chk("reset_guessed",  bus.guessed, 0);
    chk("reset_mistakes", bus.mistakes, 0);
    chk("reset_rv",       bus.result_valid, 0);
    chk("reset_winlose",  {bus.win, bus.lose}, 0);
    nRst = 1'b1;

    // "HELLO", character 0 = 'H'
    load_word("OLLEH");
    chk("load_state", bus.state, 1);
    chk("load_found", bus.found_mask, 0);

    submit("L");
    chk("L_latency",  r_lat, 6);
    chk("L_count",    r_cnt, 1);
    chk("L_hit",      r_hit, 1);
    chk("L_found",    bus.found_mask, 5'b01100);
    chk("L_mistakes", bus.mistakes, 0);
    chk("L_guessed",  bus.guessed, 26'h1 << 11);
    chk("L_state",    bus.state, 1);

    submit("L");
    chk("dup_latency", r_lat, 1);
    chk("dup_flags",   {r_hit, r_dup, r_bad}, 3'b010);
    chk("dup_found",   bus.found_mask, 5'b01100);

    submit(8'h31);
    chk("bad_latency",  r_lat, 1);
    chk("bad_flags",    {r_hit, r_dup, r_bad}, 3'b001);
    chk("bad_found",    bus.found_mask, 5'b01100);
    chk("bad_mistakes", bus.mistakes, 0);

    submit("Z");
    chk("miss1_lat", r_lat, 6); chk("miss1_hit", r_hit, 0); chk("miss1_mis", bus.mistakes, 1);
    submit("X");
    chk("miss2_mis", bus.mistakes, 2);
    submit("Q");
    chk("miss3_mis", bus.mistakes, 3);
    submit("W");
    chk("miss4_mis", bus.mistakes, 4);
    submit("V");
    chk("miss5_mis", bus.mistakes, 5); chk("miss5_state", bus.state, 1);
    submit("K");
    chk("miss6_mis",   bus.mistakes, 6);
    chk("miss6_state", bus.state, 4);
    chk("miss6_lose",  {bus.win, bus.lose}, 2'b01);
    chk("miss_guessed", bus.guessed,
        (26'h1 << 11) | (26'h1 << 25) | (26'h1 << 23) | (26'h1 << 16) |
        (26'h1 << 22) | (26'h1 << 21) | (26'h1 << 10));

    submit("H");
    chk("lose_no_rv",    r_cnt, 0);
    chk("lose_held",     bus.state, 4);
    chk("lose_mistakes", bus.mistakes, 6);

    load_word("OLLEH");
    chk("reload_state",  bus.state, 1);
    chk("reload_clear",  {bus.guessed, bus.mistakes, bus.found_mask}, 0);
    submit("H"); chk("win_H", bus.found_mask, 5'b00001);
    submit("E"); chk("win_E", bus.found_mask, 5'b00011);
    submit("L"); chk("win_L", bus.found_mask, 5'b01111);
    chk("win_notyet", bus.win, 0);
    submit("O");
    chk("win_O_hit",   r_hit, 1);
    chk("win_found",   bus.found_mask, 5'b11111);
    chk("win_flag",    {bus.win, bus.lose}, 2'b10);
    chk("win_state",   bus.state, 3);
    chk("win_mistakes", bus.mistakes, 0);

    // "AB CD": the space at index 2 is pre-revealed
    load_word("DC BA");
    chk("ab_found_load", bus.found_mask, 5'b00100);
    @(negedge clk);
    bus.data  = "A";
    bus.ready = 1'b1;
    r_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.result_valid) r_cnt++;
    end
    bus.ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.result_valid) r_cnt++;
    end
    chk("hold_one_eval", r_cnt, 1);
    chk("hold_found",    bus.found_mask, 5'b00101);

    // Abort during CHECK: sub sampled at T, game_end sampled at T+2
    @(negedge clk);
    bus.data  = "B";
    bus.ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.ready = 1'b0;
    chk("abort_in_check", bus.state, 2);
    @(negedge clk);
    bus.game_end = 1'b1;
    @(negedge clk);
    bus.game_end = 1'b0;
    chk("abort_state", bus.state, 0);
    chk("abort_outs",  {bus.found_mask, bus.guessed, bus.mistakes, bus.result_valid,
                        bus.hit, bus.dup, bus.bad, bus.win, bus.lose}, 0);
    r_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.result_valid) r_cnt++;
    end
    chk("abort_no_rv", r_cnt, 0);

    // word_load and a rising ready edge in the same PLAY cycle
    load_word("OLLEH");
    @(negedge clk);
    bus.word_in   = "EDCBA";
    bus.word_load = 1'b1;
    bus.data      = "A";
    bus.ready     = 1'b1;
    @(negedge clk);
    bus.word_load = 1'b0;
    r_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) bus.ready = 1'b0;
      if (bus.result_valid) r_cnt++;
    end
    chk("loadwins_no_rv",  r_cnt, 0);
    chk("loadwins_state",  bus.state, 1);
    chk("loadwins_masks",  {bus.found_mask, bus.guessed}, 0);

    // Word with no letters is won at load; game_end cannot leave WIN
    load_word("12345");
    chk("prerev_state", bus.state, 3);
    chk("prerev_found", bus.found_mask, 5'b11111);
    @(negedge clk);
    bus.game_end = 1'b1;
    @(negedge clk);
    bus.game_end = 1'b0;
    chk("win_ignores_abort", bus.state, 3);

    // Asynchronous reset mid-game
    load_word("OLLEH");
    submit("E");
    @(negedge clk);
    nRst = 1'b0;
    #1;
    chk("async_reset", {bus.state, bus.found_mask, bus.guessed, bus.mistakes}, 0);
    @(negedge clk);
    nRst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
